// File: rtl/axis_frame_streamer.sv
// Reads one frame of packed pixels from a synchronous frame memory and streams it in
// raster order on an AXIS master. Optional start-of-frame tuser: define AXIS_FRAME_SOF_EN.
module axis_frame_streamer #(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int IMG_WIDTH       = 16,
  parameter int IMG_HEIGHT      = 16,
  parameter int ADDR_WIDTH      = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [ADDR_WIDTH-1:0]      i_base_addr,
  output logic                       o_busy,
  output logic                       o_frame_done,
  output logic                       o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]      o_mem_rd_addr,
  input  logic [AXIS_DATA_WIDTH-1:0] i_mem_rd_data,
  output logic                       m_axis_img_tvalid,
  input  logic                       m_axis_img_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_img_tdata,
  output logic                       m_axis_img_tlast
`ifdef AXIS_FRAME_SOF_EN
  ,
  output logic                       m_axis_img_tuser
`endif
);

  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      base_q, base_d;
  logic [CNT_W-1:0]           rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]           ld_cnt_q, ld_cnt_d;
  logic                       rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]      rd_addr_q, rd_addr_d;
  logic                       inflight_q;
  logic [AXIS_DATA_WIDTH-1:0] fifo_q [2];
  logic                       fifo_wp_q, fifo_rp_q;
  logic [1:0]                 fifo_cnt_q, fifo_cnt_d;
  logic                       out_valid_q, out_valid_d;
  logic [AXIS_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                       out_last_q, out_last_d;
  logic                       done_q, done_d;
`ifdef AXIS_FRAME_SOF_EN
  logic                       out_user_q, out_user_d;
`endif

  logic                       start_s, hs_s, last_hs_s, load_s;
  logic                       fifo_pop_s, fifo_push_s, bypass_s, ld_fire_s;
  logic [2:0]                 occ_s;
  logic [AXIS_DATA_WIDTH-1:0] ld_data_s;

  // Next-state logic: FSM, read issue, prefetch FIFO and output register.
  always_comb begin
    start_s     = (state_q == S_IDLE) && i_start;
    hs_s        = out_valid_q && m_axis_img_tready;
    last_hs_s   = hs_s && out_last_q;
    load_s      = !out_valid_q || hs_s;
    fifo_pop_s  = load_s && (fifo_cnt_q != 2'd0);
    // A return arriving while the FIFO is empty and the output register can load skips the FIFO.
    bypass_s    = load_s && (fifo_cnt_q == 2'd0) && inflight_q;
    fifo_push_s = inflight_q && !bypass_s;
    ld_fire_s   = fifo_pop_s || bypass_s;
    ld_data_s   = fifo_pop_s ? fifo_q[fifo_rp_q] : i_mem_rd_data;

    if (start_s) begin
      state_d = S_RUN;
    end else if (last_hs_s) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_q;
    end

    done_d     = last_hs_s;
    base_d     = start_s ? i_base_addr : base_q;
    rd_cnt_d   = start_s ? {CNT_W{1'b0}} : rd_cnt_q + CNT_W'(rd_en_q);
    ld_cnt_d   = start_s ? {CNT_W{1'b0}} : ld_cnt_q + CNT_W'(ld_fire_s);
    fifo_cnt_d = fifo_cnt_q + 2'(fifo_push_s) - 2'(fifo_pop_s);
    // The read issued this cycle is the one in flight next cycle.
    occ_s      = 3'(fifo_cnt_d) + 3'(rd_en_q);
    rd_en_d    = (state_d == S_RUN) && (rd_cnt_d < TOTAL_C) && (occ_s < 3'd2);
    rd_addr_d  = rd_en_d ? base_d + ADDR_WIDTH'(rd_cnt_d) : rd_addr_q;

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
`ifdef AXIS_FRAME_SOF_EN
    out_user_d  = out_user_q;
`endif
    if (ld_fire_s) begin
      out_valid_d = 1'b1;
      out_data_d  = ld_data_s;
      out_last_d  = (ld_cnt_q == LAST_C);
`ifdef AXIS_FRAME_SOF_EN
      out_user_d  = (ld_cnt_q == {CNT_W{1'b0}});
`endif
    end else if (hs_s) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
`ifdef AXIS_FRAME_SOF_EN
      out_user_d  = 1'b0;
`endif
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= {ADDR_WIDTH{1'b0}};
      rd_cnt_q    <= {CNT_W{1'b0}};
      ld_cnt_q    <= {CNT_W{1'b0}};
      rd_en_q     <= 1'b0;
      rd_addr_q   <= {ADDR_WIDTH{1'b0}};
      inflight_q  <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= {AXIS_DATA_WIDTH{1'b0}};
      fifo_wp_q   <= 1'b0;
      fifo_rp_q   <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= {AXIS_DATA_WIDTH{1'b0}};
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef AXIS_FRAME_SOF_EN
      out_user_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      rd_cnt_q    <= rd_cnt_d;
      ld_cnt_q    <= ld_cnt_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      inflight_q  <= rd_en_q;
      if (fifo_push_s) fifo_q[fifo_wp_q] <= i_mem_rd_data;
      fifo_wp_q   <= fifo_wp_q ^ fifo_push_s;
      fifo_rp_q   <= fifo_rp_q ^ fifo_pop_s;
      fifo_cnt_q  <= fifo_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
`ifdef AXIS_FRAME_SOF_EN
      out_user_q  <= out_user_d;
`endif
    end
  end

  assign o_busy            = (state_q == S_RUN);
  assign o_frame_done      = done_q;
  assign o_mem_rd_en       = rd_en_q;
  assign o_mem_rd_addr     = rd_addr_q;
  assign m_axis_img_tvalid = out_valid_q;
  assign m_axis_img_tdata  = out_data_q;
  assign m_axis_img_tlast  = out_last_q;
`ifdef AXIS_FRAME_SOF_EN
  assign m_axis_img_tuser  = out_user_q;
`endif

endmodule

// File: tb/tb_axis_frame_streamer.sv
// Directed bench for axis_frame_streamer on a 4x4 frame with a synchronous memory model.
module tb_axis_frame_streamer;

  localparam int DW    = 64;
  localparam int AW    = 9;
  localparam int TOTAL = 16;

  logic          clk = 1'b0;
  logic          rst, i_start, tready;
  logic [AW-1:0] base;
  logic          busy, done, rd_en, tvalid, tlast;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, tdata;
`ifdef AXIS_FRAME_SOF_EN
  logic          tuser;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;
  int ncyc    = 0;
  int tr_mode = 0;

  int            bq_cyc[$];
  logic [DW-1:0] bq_data[$];
  logic          bq_last[$];
  logic          bq_user[$];
  logic [AW-1:0] aq[$];
  int            dq[$];

  always #5 clk = ~clk;

  axis_frame_streamer #(
    .AXIS_DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4), .ADDR_WIDTH(AW)
  ) u_dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(base),
    .o_busy(busy), .o_frame_done(done), .o_mem_rd_en(rd_en), .o_mem_rd_addr(rd_addr),
    .i_mem_rd_data(rd_data), .m_axis_img_tvalid(tvalid), .m_axis_img_tready(tready),
    .m_axis_img_tdata(tdata), .m_axis_img_tlast(tlast)
`ifdef AXIS_FRAME_SOF_EN
    , .m_axis_img_tuser(tuser)
`endif
  );

  function automatic logic [63:0] mem_val(input int a);
    return {16'hABCD, 16'(a), 16'h1234, 16'(a)};
  endfunction

  always @(posedge clk) begin
    ncyc <= ncyc + 1;
    if (rd_en) rd_data <= mem_val(int'(rd_addr));
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ready pattern generator: 0 always, 1 ~30% random, 2 toggle, other never.
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (tr_mode)
        0:       tready = 1'b1;
        1:       tready = ($urandom_range(0, 9) < 3);
        2:       tready = ~tready;
        default: tready = 1'b0;
      endcase
    end
  end

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  always @(negedge clk) begin
    if (prev_stall) begin
      check_eq("hold_valid", 64'(tvalid), 64'd1);
      check_eq("hold_data", tdata, prev_data);
      check_eq("hold_last", 64'(tlast), 64'(prev_last));
    end
    prev_stall = tvalid && !tready && !rst;
    prev_data  = tdata;
    prev_last  = tlast;
    if (!rst) begin
      if (tvalid && tready) begin
        bq_cyc.push_back(ncyc);
        bq_data.push_back(tdata);
        bq_last.push_back(tlast);
`ifdef AXIS_FRAME_SOF_EN
        bq_user.push_back(tuser);
`else
        bq_user.push_back(1'b0);
`endif
      end
      if (rd_en) aq.push_back(rd_addr);
      if (done) dq.push_back(ncyc);
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic clear_q();
    bq_cyc.delete(); bq_data.delete(); bq_last.delete(); bq_user.delete();
    aq.delete(); dq.delete();
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, output int c0);
    i_start = 1'b1;
    base    = b;
    c0      = ncyc;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int k = 0;
    while (dq.size() < n && k < budget) begin step(); k++; end
    check_eq({tag, "_done_seen"}, 64'(dq.size() >= n), 64'd1);
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k = 0;
    while (bq_data.size() < n && k < budget) begin step(); k++; end
    check_eq({tag, "_beats_seen"}, 64'(bq_data.size() >= n), 64'd1);
  endtask

  task automatic check_frame(input int first, input int b, input string tag);
    for (int k = 0; k < TOTAL; k++) begin
      if (first + k < bq_data.size()) begin
        check_eq($sformatf("%s_data%0d", tag, k), bq_data[first+k], mem_val((b + k) % 512));
        check_eq($sformatf("%s_last%0d", tag, k), 64'(bq_last[first+k]), 64'(k == TOTAL - 1));
`ifdef AXIS_FRAME_SOF_EN
        check_eq($sformatf("%s_user%0d", tag, k), 64'(bq_user[first+k]), 64'(k == 0));
`endif
      end
    end
  endtask

  task automatic check_addrs(input int b, input string tag);
    check_eq({tag, "_nrd"}, 64'(aq.size()), 64'(TOTAL));
    for (int k = 0; k < TOTAL; k++)
      if (k < aq.size()) check_eq($sformatf("%s_addr%0d", tag, k), 64'(aq[k]), 64'((b + k) % 512));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_tvalid"}, 64'(tvalid), 64'd0);
    check_eq({tag, "_tdata"}, tdata, 64'd0);
    check_eq({tag, "_tlast"}, 64'(tlast), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    check_eq({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int c0;
    rst = 1'b1; i_start = 1'b0; base = '0; tr_mode = 0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_idle_outputs("rst");

    // Full-rate frame: latency and exact cycle positions.
    clear_q(); tr_mode = 0;
    pulse_start(9'd0, c0);
    check_eq("t1_busy", 64'(busy), 64'd1);
    wait_done(1, 60, "t1");
    repeat (3) step();
    check_eq("t1_beats", 64'(bq_data.size()), 64'(TOTAL));
    check_frame(0, 0, "t1");
    check_addrs(0, "t1");
    if (bq_cyc.size() >= TOTAL) begin
      check_eq("t1_first_lat", 64'(bq_cyc[0] - c0), 64'd3);
      check_eq("t1_last_lat", 64'(bq_cyc[TOTAL-1] - c0), 64'd18);
    end
    if (dq.size() >= 1) check_eq("t1_done_lat", 64'(dq[0] - c0), 64'd19);
    check_eq("t1_done_n", 64'(dq.size()), 64'd1);
    check_eq("t1_busy_end", 64'(busy), 64'd0);

    // Random backpressure.
    clear_q(); tr_mode = 1;
    pulse_start(9'd0, c0);
    wait_done(1, 600, "t2");
    repeat (3) step();
    check_eq("t2_beats", 64'(bq_data.size()), 64'(TOTAL));
    check_frame(0, 0, "t2");
    check_addrs(0, "t2");
    check_eq("t2_done_n", 64'(dq.size()), 64'd1);

    // Address wrap-around.
    clear_q(); tr_mode = 0;
    pulse_start(9'd510, c0);
    wait_done(1, 60, "t3");
    repeat (3) step();
    check_eq("t3_beats", 64'(bq_data.size()), 64'(TOTAL));
    check_frame(0, 510, "t3");
    check_addrs(510, "t3");

    // Ignored re-starts, then back-to-back frames.
    clear_q(); tr_mode = 0;
    pulse_start(9'd0, c0);
    wait_beats(3, 60, "t4a");
    i_start = 1'b1; step(); i_start = 1'b0;
    wait_beats(9, 60, "t4b");
    i_start = 1'b1; step(); i_start = 1'b0;
    wait_beats(12, 60, "t4c");
    i_start = 1'b1;
    wait_done(1, 60, "t4d");
    i_start = 1'b0;
    wait_done(2, 60, "t4e");
    repeat (3) step();
    check_eq("t4_beats", 64'(bq_data.size()), 64'(2 * TOTAL));
    check_frame(0, 0, "t4f1");
    check_frame(TOTAL, 0, "t4f2");
    check_eq("t4_done_n", 64'(dq.size()), 64'd2);
    if (dq.size() >= 2) check_eq("t4_done_gap", 64'(dq[1] - dq[0]), 64'd19);
    if (dq.size() >= 1 && bq_cyc.size() > TOTAL)
      check_eq("t4_f2_lat", 64'(bq_cyc[TOTAL] - dq[0]), 64'd3);

    // Reset mid-frame while stalled.
    clear_q(); tr_mode = 0;
    pulse_start(9'd0, c0);
    wait_beats(7, 60, "t5");
    tr_mode = 3; tready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_outputs("t5_rst");
    clear_q(); tr_mode = 0;
    repeat (8) step();
    check_eq("t5_stray_beats", 64'(bq_data.size()), 64'd0);
    check_eq("t5_stray_done", 64'(dq.size()), 64'd0);
    check_eq("t5_stray_rd", 64'(aq.size()), 64'd0);
    pulse_start(9'd0, c0);
    wait_done(1, 60, "t5b");
    repeat (3) step();
    check_eq("t5_beats", 64'(bq_data.size()), 64'(TOTAL));
    check_frame(0, 0, "t5");

    // Toggling ready with a non-zero base.
    clear_q(); tr_mode = 2;
    pulse_start(9'd37, c0);
    wait_done(1, 200, "t6");
    repeat (3) step();
    check_eq("t6_beats", 64'(bq_data.size()), 64'(TOTAL));
    check_frame(0, 37, "t6");
    check_addrs(37, "t6");
    tr_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/axis_frame_streamer.md
Name: axis_frame_streamer

Overview:
Hardware transmitter for the accelerator's image AXI-Stream input. After a start pulse it reads one frame of IMG_WIDTH*IMG_HEIGHT packed 8-channel pixels from a synchronous frame memory and emits them in raster order on an AXIS master, one pixel per beat, with tlast on the final pixel. Connects directly to the top level's s_axis_img_* port, replacing bench-driven image injection in on-chip tests.

Parameters:
AXIS_DATA_WIDTH  64  beat width; one packed pixel (8 channels x 8 bit)
IMG_WIDTH  16  pixels per row
IMG_HEIGHT  16  rows per frame
ADDR_WIDTH  9  frame memory address width; addresses wrap modulo 2^ADDR_WIDTH

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
i_start  input  1  frame start request, sampled only in IDLE
i_base_addr  input  ADDR_WIDTH  memory address of pixel 0, latched on accepted start
o_busy  output  1  high from accepted start until the last beat handshakes
o_frame_done  output  1  one-cycle pulse after the last beat handshakes
o_mem_rd_en  output  1  memory read strobe
o_mem_rd_addr  output  ADDR_WIDTH  memory read address
i_mem_rd_data  input  AXIS_DATA_WIDTH  read data, valid exactly 1 cycle after o_mem_rd_en
m_axis_img_tvalid  output  1  AXIS valid
m_axis_img_tready  input  1  AXIS ready
m_axis_img_tdata  output  AXIS_DATA_WIDTH  pixel data
m_axis_img_tlast  output  1  high on beat TOTAL-1 only

Behaviour:
- TOTAL = IMG_WIDTH*IMG_HEIGHT. Read counter and beat counter each sized $clog2(TOTAL+1).
- Reset: all outputs 0. State IDLE. Counters, prefetch FIFO and in-flight flag cleared. Reset mid-frame aborts the frame. The read return that follows reset is discarded. No o_frame_done is produced.
- FSM:
  - IDLE -> RUN when i_start=1. On that edge, latch i_base_addr and clear the counters.
  - RUN -> IDLE on the handshake of beat TOTAL-1. In the following cycle, o_frame_done=1 and o_busy=0.
  - i_start is ignored outside IDLE.
- Read issue: 2-entry prefetch FIFO plus an output register. Assert o_mem_rd_en only when all of the following hold:
  - state=RUN;
  - reads issued < TOTAL;
  - (FIFO occupancy + reads in flight) < 2.
- o_mem_rd_addr = latched base + read index, truncated to ADDR_WIDTH. Wrap-around is silent.
- The FIFO feeds the output register. The output register loads when it is empty or the current beat handshakes.
- Timing: i_start in cycle 0 -> o_mem_rd_en in cycle 1 -> m_axis_img_tvalid in cycle 3.
- With tready held high: 1 beat/cycle sustained. The frame finishes with the last handshake in cycle TOTAL+2.
- AXIS rules:
  - Once tvalid is asserted, tvalid/tdata/tlast stay stable until tready=1.
  - tvalid never depends combinationally on tready.
  - No beat is lost or duplicated under any tready pattern.
- tlast = (beat index == TOTAL-1) for the beat currently presented.
- Simultaneous FIFO write (read return) and read (output-register load) in one cycle: occupancy unchanged. The FIFO never overflows.
- A new frame may start in the cycle after o_frame_done (back-to-back frames).
- o_busy = (state==RUN).

Optional Feature:
AXIS_FRAME_SOF_EN
- Defined: adds output port m_axis_img_tuser (1 bit, reset 0). It is high on beat 0 of each frame only and follows the same stability rule as tdata.
- Undefined: the port does not exist and there is no related logic.

Test Plan:
1. IMG 4x4, base=0, mem[k]=k, tready=1, pulse i_start -> 16 beats on consecutive cycles.
   - tdata = 0..15, tlast only on beat 15.
   - First tvalid 3 cycles after start; o_frame_done pulses once, in the cycle after beat 15.
2. Same frame, tready pseudo-random at 30% high -> identical 16-value sequence.
   - tdata/tlast stable while tvalid=1 and tready=0; the FIFO never overflows.
3. ADDR_WIDTH=9, base=510, 4x4 frame -> read addresses 510, 511, 0, 1, ..., 13; tdata matches those locations.
4. i_start re-pulsed at beats 3 and 9 -> ignored. Then i_start held high through o_frame_done -> second frame starts immediately.
   - Total 32 beats with tlast on beats 15 and 31.
5. Assert rst for 1 cycle after beat 6 with tready low -> next cycle all outputs 0.
   - No stray beat or o_frame_done; a subsequent start yields a clean 16-beat frame.
6. 16x16 frame with AXIS_FRAME_SOF_EN defined and tready toggling every cycle -> 256 beats.
   - tuser=1 only on beat 0; tlast only on beat 255.
